// File: rtl/mux_rr_n.sv
// N-channel registered mux with valid/ready output and fixed or round-robin selection.
// Optional even-parity output register enabled by defining MUX_RR_PARITY_EN.
module mux_rr_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = $clog2(CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH*WIDTH-1:0] din_i,
  input  logic [CH-1:0]      din_valid_i,
  output logic [CH-1:0]      din_ack_o,
  input  logic               mode_i,
  input  logic [SELW-1:0]    sel_i,
  output logic [WIDTH-1:0]   dout_o,
  output logic [SELW-1:0]    dout_ch_o,
  output logic               dout_valid_o,
`ifdef MUX_RR_PARITY_EN
  output logic               dout_par_o,
`endif
  input  logic               dout_ready_i
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0]  dout_ch_q, dout_ch_d;
  logic             dout_valid_q, dout_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [SELW-1:0]  cand;
  logic             cand_vld;
  logic [WIDTH-1:0] cand_word;
  logic [SELW-1:0]  ridx;
  logic             load;
  logic             grant;

  // Candidate selection. The round-robin loop walks offsets from far to near so the
  // nearest requesting channel after ptr is the last (winning) assignment.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    ridx     = '0;
    if (!mode_i) begin
      for (int unsigned k = 0; k < CH; k++) begin
        if (sel_i == SELW'(k) && din_valid_i[k]) begin
          cand     = SELW'(k);
          cand_vld = 1'b1;
        end
      end
    end else begin
      for (int unsigned off = CH; off > 0; off--) begin
        ridx = SELW'((32'(ptr_q) + off) % CH);
        if (din_valid_i[ridx]) begin
          cand     = ridx;
          cand_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cand_word = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (cand == SELW'(k)) begin
        cand_word = din_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign load  = !dout_valid_q || dout_ready_i;
  // Reset gates the ack so no producer sees its word taken while the register is cleared.
  assign grant = rst_n && load && cand_vld;

  always_comb begin
    din_ack_o = '0;
    if (grant) begin
      din_ack_o = CH'(1) << cand;
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q;
    ptr_d        = ptr_q;
    if (load) begin
      dout_valid_d = cand_vld;
      if (cand_vld) begin
        dout_d    = cand_word;
        dout_ch_d = cand;
        ptr_d     = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      ptr_q        <= SELW'(CH - 1);
    end else begin
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_ch_o    = dout_ch_q;
  assign dout_valid_o = dout_valid_q;

`ifdef MUX_RR_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load && cand_vld) begin
      par_d = ^cand_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign dout_par_o = par_q;
`endif

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel registered multiplexer with a valid/ready output handshake and two selection modes: fixed (external select) and round-robin (automatic fair scan over requesting channels). It generalises the team's combinational 4:1 mux to arbitrary width and channel count. It sits between several producer channels and one downstream consumer, returning a one-hot acknowledge to the channel whose word was taken.

## Interface
- `WIDTH`, default 8: data width per channel, minimum 1.
- `CH`, default 4: number of channels, 2..16.
- `SELW`, default `$clog2(CH)`: select/index width. It is derived and must not be overridden.

- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: reset. It is asynchronous and active-low.
- `din` in CH*WIDTH: channel k occupies `[k*WIDTH +: WIDTH]`.
- `din_valid` in CH: per-channel request, one bit per channel.
- `din_ack` out CH: one-hot, combinational. High in the cycle whose rising edge captures that channel.
- `mode` in 1: 0 = fixed select, 1 = round-robin.
- `sel` in SELW: channel to use when `mode`=0.
- `dout` out WIDTH: registered output data.
- `dout_ch` out SELW: index of the channel that produced `dout`.
- `dout_valid` out 1: output register holds an unconsumed word.
- `dout_ready` in 1: consumer accepts `dout` this cycle.

## Operation
- The output register has two states, EMPTY (`dout_valid`=0) and FULL (`dout_valid`=1).
- `load` = !dout_valid || dout_ready. A new word may enter the register only when `load`=1.
- Candidate selection in fixed mode (`mode`=0):
  - The candidate is `sel` if `din_valid[sel]`=1.
  - If `sel` ≥ CH, or `din_valid[sel]`=0, there is no candidate.
- Candidate selection in round-robin mode (`mode`=1):
  - Search the channels in order ptr+1, ptr+2, … modulo CH.
  - The first channel with `din_valid` set is the candidate.
- Grant is `load` AND a candidate exists. On grant:
  - `din_ack[cand]`=1.
  - At the edge: `dout`<=din[cand], `dout_ch`<=cand, `dout_valid`<=1, ptr<=cand.
- Load with no candidate: at the edge `dout_valid`<=0. `dout` and `dout_ch` hold their last values.
- No load (FULL and `dout_ready`=0): all outputs hold, and `din_ack`=0.
- ptr updates on every grant in either mode. A mode switch therefore continues the scan from the last granted channel.
- A `mode`/`sel` change takes effect on the next selection. It never disturbs a word already held.
- At most one `din_ack` bit is high per cycle. A channel holding `din_valid` high with unchanged data after its ack is treated as a new request.

## Timing
- Reset (asynchronous, immediate) sets:
  - `dout`=0, `dout_ch`=0, `dout_valid`=0.
  - ptr=CH-1, so channel 0 has first priority after reset.
  - `din_ack`=0 while `rst_n`=0.
- Latency: `din_valid` high in cycle n with a grant gives `dout_valid`=1 in cycle n+1.
- Throughput: one word per cycle while `dout_ready`=1 and requests are present.
- Simultaneous consume and refill: FULL with `dout_ready`=1 and a candidate present reloads in the same edge. `dout_valid` stays 1 with no bubble.
- Reset asserted mid-transfer: the held word is discarded and no ack is issued. After release, the first grant follows the round-robin order from channel 0.
- `din_ack` depends combinationally on `din_valid`, `mode`, `sel`, `dout_ready` and state. Producers must not feed it back combinationally into `din_valid`.

## Configuration
- `MUX_RR_PARITY_EN` defined:
  - Adds output port `dout_par` (1 bit), registered alongside `dout`.
  - `dout_par` = even parity of the captured word (XOR-reduce of `din[cand]`).
  - Reset value 0. It holds whenever `dout` holds.
- `MUX_RR_PARITY_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: drive `rst_n`=0 between clock edges. Outputs go to zero immediately: `dout`=0, `dout_ch`=0, `dout_valid`=0, `din_ack`=0.
- Fixed mode, WIDTH=8, CH=4:
  - Stimulus: `mode`=0, `sel`=2, `din_valid`=4'b0100, ch2=8'hA5, `dout_ready`=1.
  - Response: `din_ack`=4'b0100 for one cycle. Next cycle `dout`=8'hA5, `dout_ch`=2, `dout_valid`=1.
  - Then `sel`=3 with `din_valid[3]`=0: `dout_valid` falls to 0 and `dout` holds 8'hA5.
- Round-robin fairness:
  - Stimulus: `mode`=1, `din_valid`=4'b1111, `dout_ready`=1.
  - Response: `dout_ch` sequence 0,1,2,3,0,1 on consecutive cycles, with exactly one-hot `din_ack` each cycle.
  - With `din_valid`=4'b1010, the sequence is 1,3,1,3.
- Backpressure:
  - Stimulus: FULL with `dout`=8'h3C, then `dout_ready`=0 for 5 cycles.
  - Response: `dout`, `dout_ch` and `dout_valid` stable; `din_ack`=0 throughout.
  - Raise `dout_ready`: the next channel is acked in the same cycle, `dout_valid` stays 1 and `dout` updates at the edge.
- Mode switch and reset mid-stream:
  - Round-robin grants ch1. Switch to `mode`=0 with `sel`=3 and grant ch3. Switch back to `mode`=1 with all channels valid: the next grant is ch0.
  - Assert `rst_n` with `dout_valid`=1: the word is dropped. After release the first grant is ch0.
- Parity (`MUX_RR_PARITY_EN` defined):
  - Capture 8'hA5: `dout_par`=0.
  - Capture 8'hA4: `dout_par`=1.
